// File: rtl/con_seq_ctrl_if.sv
// con_seq_ctrl_if: handshake and result bus between the convolution sequencer and its neighbours
// (window buffer, conv core, result store).
interface con_seq_ctrl_if #(
    parameter int unsigned CW = 10
);
    logic          start;
    logic          busy;
    logic          done;
    logic          wei_req;
    logic          wei_ack;
    logic          win_valid;
    logic          win_ready;
    logic [CW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          con_en;
    logic          con_valid;
    logic          res_wr;
    logic [2*CW-1:0] res_addr;
    logic          res_credit;
    logic          err;

    modport master (
        input  start, wei_ack, win_valid, con_valid, res_credit,
        output busy, done, wei_req, win_ready, win_row, win_col, con_en, res_wr, res_addr, err
    );

    modport slave (
        output start, wei_ack, win_valid, con_valid, res_credit,
        input  busy, done, wei_req, win_ready, win_row, win_col, con_en, res_wr, res_addr, err
    );
endinterface

// File: rtl/con_seq_ctrl.sv
// con_seq_ctrl: sequencer for the 7x7 pipelined convolution core. Loads coefficients, walks every
// valid output position (stride 1, no padding) under downstream credit control, and indexes results.
module con_seq_ctrl #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter int unsigned KSIZE   = 7,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 10
) (
    input  logic           clk,
    input  logic           rst,
    con_seq_ctrl_if.master ctrl_io
);
    localparam int unsigned OutW  = IMG_W - KSIZE + 1;
    localparam int unsigned OutH  = IMG_H - KSIZE + 1;
    localparam int unsigned Total = OutW * OutH;
    localparam int unsigned CredW = $clog2(CREDITS + 1);

    localparam logic [CW-1:0]    LastCol  = CW'(OutW - 1);
    localparam logic [CW-1:0]    LastRow  = CW'(OutH - 1);
    localparam logic [2*CW-1:0]  TotalIdx = (2*CW)'(Total);
    localparam logic [CredW-1:0] CredMax  = CredW'(CREDITS);

    typedef enum logic [2:0] {StIdle, StWload, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [2*CW-1:0] addr_q, addr_d;
    logic [3:0]      infl_q, infl_d;
    logic [CredW-1:0] cred_q, cred_d;
    logic            err_q, err_d;
    logic            busy, issue, cv_ok, wr;

    // Handshake decode shared by the counters and the FSM
    always_comb begin
        busy  = (state_q != StIdle);
        issue = (state_q == StRun) && ctrl_io.win_valid && (cred_q != '0);
        cv_ok = ctrl_io.con_valid && (infl_q != '0);
        wr    = cv_ok && busy;
    end

    // In-flight and credit counters plus the sticky protocol error
    always_comb begin
        infl_d = infl_q;
        if (issue && !cv_ok) begin
            infl_d = infl_q + 4'd1;
        end else if (!issue && cv_ok) begin
            infl_d = infl_q - 4'd1;
        end

        // A credit returned in the same cycle as an issue cancels it, even at full credit
        cred_d = cred_q;
        if (issue && !ctrl_io.res_credit) begin
            cred_d = cred_q - CredW'(1);
        end else if (!issue && ctrl_io.res_credit && (cred_q != CredMax)) begin
            cred_d = cred_q + CredW'(1);
        end

        err_d = err_q
              | (ctrl_io.con_valid && (infl_q == '0))
              | (ctrl_io.res_credit && !issue && (cred_q == CredMax))
              | (ctrl_io.wei_ack && (state_q != StWload));
    end

    // Sequencer FSM with window position and result index next state
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q + (2*CW)'(wr);
        case (state_q)
            StIdle:  if (ctrl_io.start) state_d = StWload;
            StWload: if (ctrl_io.wei_ack) state_d = StRun;
            StRun: begin
                if (issue) begin
                    if (col_q == LastCol) begin
                        // Last position holds row/col until the return to idle
                        if (row_q == LastRow) begin
                            state_d = StDrain;
                        end else begin
                            col_d = '0;
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            // Next-state values so done follows the final write by exactly one cycle
            StDrain: if ((infl_d == '0) && (addr_d == TotalIdx)) state_d = StDone;
            StDone: begin
                state_d = StIdle;
                row_d   = '0;
                col_d   = '0;
                addr_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            infl_q  <= '0;
            cred_q  <= CredMax;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            infl_q  <= infl_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    assign ctrl_io.busy      = busy;
    assign ctrl_io.done      = (state_q == StDone);
    assign ctrl_io.wei_req   = (state_q == StWload);
    assign ctrl_io.win_ready = issue;
    assign ctrl_io.con_en    = issue;
    assign ctrl_io.win_row   = row_q;
    assign ctrl_io.win_col   = col_q;
    assign ctrl_io.res_wr    = wr;
    assign ctrl_io.res_addr  = addr_q;
    assign ctrl_io.err       = err_q;
endmodule

// File: tb/tb_con_seq_ctrl.sv
// tb_con_seq_ctrl: two 9x9 sequencers (16 and 2 credits) driven by a 7-cycle core model.
module tb_con_seq_ctrl;
    localparam int unsigned Cw    = 10;
    localparam int          Ow    = 3;
    localparam int          Tot   = 9;
    localparam int          CredA = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    con_seq_ctrl_if #(.CW(Cw)) a_if ();
    con_seq_ctrl_if #(.CW(Cw)) b_if ();

    con_seq_ctrl #(.IMG_W(9), .IMG_H(9), .KSIZE(7), .CREDITS(16), .CW(Cw)) u_a (
        .clk(clk), .rst(rst), .ctrl_io(a_if)
    );
    con_seq_ctrl #(.IMG_W(9), .IMG_H(9), .KSIZE(7), .CREDITS(2), .CW(Cw)) u_b (
        .clk(clk), .rst(rst), .ctrl_io(b_if)
    );

    // Core model: result valid 7 cycles after each enable
    logic [6:0] pipe_a, pipe_b;
    logic echo_a, echo_b, rc_a, rc_b, inj_a;
    int   owed_a;
    assign a_if.con_valid  = pipe_a[6] | inj_a;
    assign b_if.con_valid  = pipe_b[6];
    assign a_if.res_credit = echo_a ? a_if.res_wr : rc_a;
    assign b_if.res_credit = echo_b ? b_if.res_wr : rc_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_a <= '0;
            pipe_b <= '0;
            owed_a <= 0;
        end else begin
            pipe_a <= {pipe_a[5:0], a_if.con_en};
            pipe_b <= {pipe_b[5:0], b_if.con_en};
            owed_a <= (owed_a + int'(a_if.res_wr) - int'(a_if.res_credit) < 0) ? 0 :
                      owed_a + int'(a_if.res_wr) - int'(a_if.res_credit);
        end
    end

    logic [46:0] out_a, out_b;
    assign out_a = {a_if.busy, a_if.done, a_if.wei_req, a_if.win_ready, a_if.con_en, a_if.res_wr,
                    a_if.err, a_if.win_row, a_if.win_col, a_if.res_addr};
    assign out_b = {b_if.busy, b_if.done, b_if.wei_req, b_if.win_ready, b_if.con_en, b_if.res_wr,
                    b_if.err, b_if.win_row, b_if.win_col, b_if.res_addr};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model of DUT A: phase 0 idle,1 load,2 run,3 drain,4 done; linear position index
    int m_ph, m_pos, m_wr, m_inf, m_cred;
    bit m_err;

    task automatic model_step();
        logic e_busy, e_iss, e_wr;
        logic [46:0] ev;
        if (rst) begin
            m_ph = 0; m_pos = 0; m_wr = 0; m_inf = 0; m_cred = CredA; m_err = 0;
        end
        e_busy = (m_ph != 0);
        e_iss  = (m_ph == 2) && a_if.win_valid && (m_cred > 0);
        e_wr   = e_busy && a_if.con_valid && (m_inf > 0);
        ev = {e_busy, (m_ph == 4), (m_ph == 1), e_iss, e_iss, e_wr, m_err,
              10'(m_pos / Ow), 10'(m_pos % Ow), 20'(m_wr)};
        chk("model_a", 64'(out_a), 64'(ev));
        if (!rst) begin
            if ((a_if.con_valid && m_inf == 0) || (a_if.res_credit && !e_iss && m_cred == CredA) ||
                (a_if.wei_ack && m_ph != 1)) m_err = 1;
            if (a_if.con_valid && m_inf > 0) m_inf--;
            if (e_iss) m_inf++;
            m_cred = m_cred - int'(e_iss) + int'(a_if.res_credit);
            if (m_cred > CredA) m_cred = CredA;
            if (e_wr) m_wr++;
            case (m_ph)
                0: if (a_if.start) m_ph = 1;
                1: if (a_if.wei_ack) m_ph = 2;
                2: if (e_iss) begin
                    if (m_pos == Tot - 1) m_ph = 3;
                    else m_pos++;
                end
                3: if (m_inf == 0 && m_wr == Tot) m_ph = 4;
                default: begin m_ph = 0; m_pos = 0; m_wr = 0; end
            endcase
        end
    endtask

    // One clock: model on the falling edge, then return 1ns after the rising edge
    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // One full map on DUT A with credits echoed; optional start pokes in RUN and DONE
    task automatic run_a(input bit poke);
        int n_en, n_wr, n_done, en_first, en_last, wr_t, done_t;
        bit done_next;
        n_en = 0; n_wr = 0; n_done = 0; en_first = -1; en_last = -1; wr_t = -1; done_t = -1;
        done_next = 0;
        echo_a = 1; a_if.win_valid = 1;
        a_if.start = 1; cyc(); a_if.start = 0;
        settle(); chk("t2_wreq1", a_if.wei_req, 1); cyc();
        settle(); chk("t2_wreq2", a_if.wei_req, 1); cyc();
        a_if.wei_ack = 1; settle(); chk("t2_wreq3", a_if.wei_req, 1); cyc();
        a_if.wei_ack = 0;
        for (int t = 0; t < 40; t++) begin
            a_if.start = poke && (t == 2 || done_next);
            done_next = 0;
            settle();
            if (t == 0) chk("t2_wreq_drop", a_if.wei_req, 0);
            if (a_if.con_en) begin
                chk("t2_row", a_if.win_row, n_en / Ow);
                chk("t2_col", a_if.win_col, n_en % Ow);
                if (en_first < 0) en_first = t;
                en_last = t;
                n_en++;
            end
            if (a_if.res_wr) begin
                chk("t2_addr", a_if.res_addr, n_wr);
                n_wr++;
                wr_t = t;
                if (n_wr == Tot) done_next = 1;
            end
            if (a_if.done) begin
                n_done++;
                done_t = t;
            end
            cyc();
        end
        a_if.start = 0; a_if.win_valid = 0; echo_a = 0;
        chk("t2_issues", n_en, Tot);
        chk("t2_first_issue", en_first, 0);
        chk("t2_consecutive", en_last - en_first, Tot - 1);
        chk("t2_writes", n_wr, Tot);
        chk("t5_single_done", n_done, 1);
        chk("t2_done_after_wr", done_t, wr_t + 1);
        chk("t2_done_after_en", done_t, en_last + 8);
        settle();
        chk("t2_idle", a_if.busy, 0);
        chk("t2_err", a_if.err, 0);
        cyc();
    endtask

    typedef struct {
        bit wv;
        bit rc;
        bit en;
        int row;
        int col;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_en_b, n_done_b;
        tbl[0]  = '{1, 0, 1, 0, 0};  tbl[1]  = '{0, 0, 0, 0, 1};  tbl[2]  = '{0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 1, 0, 1};  tbl[4]  = '{1, 0, 0, 0, 2};  tbl[5]  = '{1, 0, 0, 0, 2};
        tbl[6]  = '{1, 1, 0, 0, 2};  tbl[7]  = '{1, 0, 1, 0, 2};  tbl[8]  = '{1, 0, 0, 1, 0};
        tbl[9]  = '{1, 1, 0, 1, 0};  tbl[10] = '{0, 0, 0, 1, 0};  tbl[11] = '{1, 0, 1, 1, 0};
        tbl[12] = '{1, 0, 0, 1, 1};

        rst = 1;
        {a_if.start, a_if.wei_ack, a_if.win_valid} = '0;
        {b_if.start, b_if.wei_ack, b_if.win_valid} = '0;
        {echo_a, echo_b, rc_a, rc_b, inj_a} = '0;
        cyc(); cyc();
        settle();
        chk("reset_a", 64'(out_a), 0);
        chk("reset_b", 64'(out_b), 0);
        cyc();
        rst = 0;
        cyc();

        // T3/T4 on the 2-credit instance: credit stalls and gapped window valid
        b_if.start = 1; cyc(); b_if.start = 0;
        b_if.wei_ack = 1; settle(); chk("b_wreq", b_if.wei_req, 1); chk("b_busy", b_if.busy, 1);
        cyc(); b_if.wei_ack = 0;
        n_en_b = 0; n_done_b = 0;
        for (int i = 0; i < 13; i++) begin
            b_if.win_valid = tbl[i].wv;
            rc_b = tbl[i].rc;
            settle();
            chk($sformatf("b_en[%0d]", i), b_if.con_en, tbl[i].en);
            chk($sformatf("b_ready[%0d]", i), b_if.win_ready, tbl[i].en);
            chk($sformatf("b_row[%0d]", i), b_if.win_row, tbl[i].row);
            chk($sformatf("b_col[%0d]", i), b_if.win_col, tbl[i].col);
            n_en_b += int'(b_if.con_en);
            cyc();
        end
        rc_b = 0; echo_b = 1; b_if.win_valid = 1;
        for (int t = 0; t < 120; t++) begin
            settle();
            n_en_b += int'(b_if.con_en);
            n_done_b += int'(b_if.done);
            cyc();
        end
        b_if.win_valid = 0;
        settle();
        chk("b_total_issues", n_en_b, Tot);
        chk("b_done_count", n_done_b, 1);
        chk("b_err", b_if.err, 0);
        chk("b_idle", b_if.busy, 0);
        cyc();

        // T2/T5 on the 16-credit instance
        run_a(1);
        run_a(0);

        // T1: asynchronous reset in the middle of a run
        a_if.win_valid = 1;
        a_if.start = 1; cyc(); a_if.start = 0;
        a_if.wei_ack = 1; cyc(); a_if.wei_ack = 0;
        cyc(); cyc();
        settle(); chk("t1_running", a_if.con_en, 1);
        cyc();
        rst = 1;
        #1;
        chk("t1_async_reset", 64'(out_a), 0);
        cyc();
        rst = 0; a_if.win_valid = 0;
        cyc();

        // T6: protocol errors
        inj_a = 1; settle(); chk("t6_no_wr", a_if.res_wr, 0); cyc();
        inj_a = 0; settle(); chk("t6_cv_err", a_if.err, 1);
        repeat (4) cyc();
        settle(); chk("t6_sticky", a_if.err, 1);
        cyc(); rst = 1; cyc(); rst = 0;
        rc_a = 1; settle(); chk("t6_err_clear", a_if.err, 0); cyc();
        rc_a = 0; settle(); chk("t6_excess_credit", a_if.err, 1);
        cyc(); rst = 1; cyc(); rst = 0;
        a_if.wei_ack = 1; cyc(); a_if.wei_ack = 0;
        settle(); chk("t6_stray_ack", a_if.err, 1);
        cyc(); rst = 1; cyc(); rst = 0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            a_if.start     = ($urandom_range(7) == 0);
            a_if.wei_ack   = (a_if.wei_req && $urandom_range(2) == 0) || ($urandom_range(299) == 0);
            a_if.win_valid = ($urandom_range(1) == 1);
            rc_a  = (owed_a > 0 && $urandom_range(1) == 1) || ($urandom_range(255) == 0);
            inj_a = ($urandom_range(399) == 0);
            rst   = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 0; inj_a = 0; rc_a = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
